// File: rtl/dual_prio_decoder.sv
// rtl/dual_prio_decoder.sv - priority-index pair decoder with output FIFO (optional error counter: DPD_ERRCNT_EN)
module dual_prio_decoder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  first,
    input  logic [3:0]  second,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef DPD_ERRCNT_EN
    output logic        err,
    output logic [7:0]  err_cnt
`else
    output logic        err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0] NONE = 4'hF;

    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          accept, illegal, push, pop;
    logic [11:0]   vec;

    function automatic logic [11:0] decode(input logic [3:0] idx);
        decode = (idx < 4'd12) ? (12'b1 << idx) : 12'b0;
    endfunction

    // Indices 12..14 are reserved; a valid pair is strictly descending with F only trailing.
    always_comb begin
        illegal = 1'b0;
        if ((first >= 4'd12 && first != NONE) || (second >= 4'd12 && second != NONE))
            illegal = 1'b1;
        else if (first == NONE && second != NONE)
            illegal = 1'b1;
        else if (first != NONE && second != NONE && first <= second)
            illegal = 1'b1;
    end

    assign vec       = decode(first) | decode(second);
    assign in_ready  = (cnt_q < DEPTH_C);
    assign out_valid = (cnt_q != '0);
    assign out       = out_valid ? mem_q[rd_ptr_q] : 12'b0;
    assign err       = err_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && !illegal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = accept && illegal;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: out is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= vec;
    end

`ifdef DPD_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && illegal && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dual_prio_decoder.sv
// tb/tb_dual_prio_decoder.sv - self-checking bench for dual_prio_decoder
module tb_dual_prio_decoder;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  first, second;
    logic        in_valid, in_ready;
    logic [11:0] out;
    logic        out_valid, out_ready, err;
`ifdef DPD_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    dual_prio_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .first(first), .second(second),
        .in_valid(in_valid), .in_ready(in_ready), .out(out),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef DPD_ERRCNT_EN
        .err(err), .err_cnt(err_cnt)
`else
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mq[$];
    bit err_exp = 0;
    int cnt_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_illegal(input int f, input int s);
        if ((f >= 12 && f <= 14) || (s >= 12 && s <= 14)) return 1;
        if (f == 15 && s != 15) return 1;
        if (f != 15 && s != 15 && f <= s) return 1;
        return 0;
    endfunction

    function automatic int m_vec(input int f, input int s);
        return (f == 15 ? 0 : 2 ** f) + (s == 15 ? 0 : 2 ** s);
    endfunction

    // Entered just after a rising edge; checks before the next edge, then models that edge.
    task automatic cycle(input bit v, input int f, input int s, input bit ordy);
        bit acc;
        in_valid = v; first = 4'(f); second = 4'(s); out_ready = ordy;
        @(negedge clk);
        chk("in_ready", in_ready, (mq.size() < DEPTH));
        chk("out_valid", out_valid, (mq.size() > 0));
        chk("out", out, mq.size() > 0 ? mq[0] : 0);
        chk("err", err, err_exp);
`ifdef DPD_ERRCNT_EN
        chk("err_cnt", err_cnt, cnt_exp);
`endif
        acc = v && (mq.size() < DEPTH);
        if (mq.size() > 0 && ordy) void'(mq.pop_front());
        if (acc && !m_illegal(f, s)) mq.push_back(m_vec(f, s));
        err_exp = acc && m_illegal(f, s);
        if (err_exp && cnt_exp < 255) cnt_exp++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; first = 4'hF; second = 4'hF; out_ready = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", out, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Accept on the first edge after release; (9,6) decodes to bits 9 and 6
        cycle(1, 9, 6, 0);
        chk("req033_out", out, 12'b001001000000);
        chk("req033_valid", out_valid, 1);
        cycle(0, 15, 15, 1);

        // Fill the depth-2 queue, third pair must be ignored
        cycle(1, 11, 10, 0);
        cycle(1, 5, 0, 0);
        chk("req034_full", in_ready, 0);
        cycle(1, 7, 1, 0);
        cycle(0, 15, 15, 0);
        chk("req034_pop1", out, 12'b110000000000);
        cycle(0, 15, 15, 1);
        chk("req034_pop2", out, 12'b000000100001);
        cycle(0, 15, 15, 1);

        // Illegal pairs pulse err and push nothing
        cycle(1, 3, 3, 0);
        cycle(1, 13, 2, 0);
        cycle(1, 15, 4, 0);
        cycle(0, 15, 15, 0);
        chk("req035_empty", out_valid, 0);
`ifdef DPD_ERRCNT_EN
        chk("req035_cnt", err_cnt, 3);
`endif

        // Null pair is legal; then streaming push+pop keeps occupancy at 1
        cycle(1, 15, 15, 0);
        chk("req036_null", out, 0);
        chk("req036_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) cycle(1, i + 1, i, 1);
        chk("req036_occ", mq.size(), 1);
        cycle(0, 15, 15, 1);

        // Asynchronous reset mid-cycle with two entries queued
        cycle(1, 8, 2, 0);
        cycle(1, 6, 15, 0);
        rst_n = 1'b0;
        #1;
        chk("req037_valid", out_valid, 0);
        chk("req037_ready", in_ready, 1);
        chk("req037_out", out, 0);
        mq.delete(); err_exp = 0; cnt_exp = 0;
        #2 rst_n = 1'b1;
        cycle(0, 15, 15, 1);
        cycle(0, 15, 15, 1);

        // Error counter saturation
        for (int i = 0; i < 300; i++) cycle(1, 3, 3, 1);
        cycle(0, 15, 15, 1);
`ifdef DPD_ERRCNT_EN
        chk("req038_sat", err_cnt, 8'hFF);
`endif

        // Randomised traffic against the reference queue
        for (int i = 0; i < 500; i++) begin
            int f, s;
            if ($urandom_range(0, 1) == 1) begin
                f = $urandom_range(0, 11);
                s = (f == 0 || $urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, f - 1);
            end else begin
                f = $urandom_range(0, 15);
                s = $urandom_range(0, 15);
            end
            cycle($urandom_range(0, 3) != 0, f, s, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
